// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready flow control.
// Shift levels are applied MSB first and spread across STAGES register stages.
module shifter_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           DIN_SP,
    input  logic [$clog2(WIDTH)-1:0]   SHIFT_VAL_SP,
    input  logic [2:0]                 CMD_SP,
    input  logic                       IN_VALID_SP,
    output logic                       IN_READY_SP,
    input  logic                       FLUSH_SP,
    output logic [WIDTH-1:0]           DOUT_SP,
    output logic                       ZERO_SP,
    output logic                       OUT_VALID_SP,
    input  logic                       OUT_READY_SP
);

    localparam int LEVELS = $clog2(WIDTH);

    localparam logic [2:0] CMD_SLL = 3'b000;
    localparam logic [2:0] CMD_SRL = 3'b001;
    localparam logic [2:0] CMD_SRA = 3'b010;
    localparam logic [2:0] CMD_ROL = 3'b011;
    localparam logic [2:0] CMD_ROR = 3'b100;

    // Stage that owns level lvl (lvl 0 is the largest shift); each stage
    // takes ceil(remaining levels / remaining stages).
    function automatic int level_stage(input int lvl);
        int rem;
        int start;
        int n;
        int res;
        rem   = LEVELS;
        start = 0;
        res   = STAGES - 1;
        for (int s = 0; s < STAGES; s++) begin
            n = (rem + STAGES - s - 1) / (STAGES - s);
            if (lvl >= start && lvl < start + n) res = s;
            start = start + n;
            rem   = rem - n;
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       cmd,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (cmd)
            CMD_SLL: res = x << amt;
            CMD_SRL: res = x >> amt;
            CMD_SRA: res = (x >> amt) | (sign ? ~(ones >> amt) : '0);
            CMD_ROL: res = (x << amt) | (x >> (WIDTH - amt));
            CMD_ROR: res = (x >> amt) | (x << (WIDTH - amt));
            default: res = x;
        endcase
        return res;
    endfunction

    // data_p[STAGES] is the output register; the others are compute stages.
    logic [WIDTH-1:0]  data_p [STAGES+1];
    logic [2:0]        cmd_p  [STAGES];
    logic [LEVELS-1:0] shv_p  [STAGES];
    logic [STAGES-1:0] sign_p;
    logic [STAGES:0]   vld_p;
    logic              zero_p;

    logic [STAGES:0]   adv;
    logic [WIDTH-1:0]  nxt [STAGES+1];

    // A stage advances unless it and every stage after it are full and stalled.
    always_comb begin
        logic full;
        adv = '0;
        for (int k = 0; k <= STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j <= STAGES; j++) full = full & vld_p[j];
            adv[k] = !full || OUT_READY_SP;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] x;
        nxt[0] = DIN_SP;
        for (int k = 0; k < STAGES; k++) begin
            x = data_p[k];
            for (int lvl = 0; lvl < LEVELS; lvl++) begin
                if (level_stage(lvl) == k && shv_p[k][LEVELS-1-lvl])
                    x = shift_level(x, cmd_p[k], sign_p[k], 1 << (LEVELS - 1 - lvl));
            end
            nxt[k+1] = x;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p  <= '0;
            zero_p <= 1'b1;
            sign_p <= '0;
            for (int k = 0; k <= STAGES; k++) data_p[k] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                cmd_p[k] <= '0;
                shv_p[k] <= '0;
            end
        end else begin
            if (FLUSH_SP) begin
                vld_p <= '0;
            end else begin
                if (adv[0]) vld_p[0] <= IN_VALID_SP;
                for (int k = 1; k <= STAGES; k++)
                    if (adv[k]) vld_p[k] <= vld_p[k-1];
            end

            // stage 0: capture operand and control
            if (adv[0]) begin
                data_p[0] <= DIN_SP;
                cmd_p[0]  <= CMD_SP;
                shv_p[0]  <= SHIFT_VAL_SP;
                sign_p[0] <= DIN_SP[WIDTH-1];
            end

            // stages 1..STAGES-1: partial shift results travel with control
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    data_p[k] <= nxt[k];
                    cmd_p[k]  <= cmd_p[k-1];
                    shv_p[k]  <= shv_p[k-1];
                    sign_p[k] <= sign_p[k-1];
                end
            end

            // output register
            if (adv[STAGES]) begin
                data_p[STAGES] <= nxt[STAGES];
                zero_p         <= (nxt[STAGES] == '0);
            end
        end
    end

    assign IN_READY_SP  = adv[0];
    assign DOUT_SP      = data_p[STAGES];
    assign ZERO_SP      = zero_p;
    assign OUT_VALID_SP = vld_p[STAGES];

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed WIDTH=32/STAGES=2 vectors plus
// random streams on every WIDTH in {8,32,64} and every legal STAGES.
module tb_shifter_pipe;

    localparam int NCFG = 14;

    logic        clk;
    logic        rst;
    logic        rrst;
    logic [31:0] din;
    logic [4:0]  shv;
    logic [2:0]  cmd;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] dout;
    logic        zero;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];

    bit          hold_en = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_dout = '0;

    shifter_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
        .CLK(clk), .RESET(rst), .DIN_SP(din), .SHIFT_VAL_SP(shv), .CMD_SP(cmd),
        .IN_VALID_SP(in_valid), .IN_READY_SP(in_ready), .FLUSH_SP(flush),
        .DOUT_SP(dout), .ZERO_SP(zero), .OUT_VALID_SP(out_valid),
        .OUT_READY_SP(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Hold a request until accepted; the expected result is queued on accept.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [2:0] c,
                        input logic [31:0] e, input bit lat);
        bit done;
        done = 0;
        din = d; shv = s; cmd = c; in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                sb.push_back('{data: e, zero: (e == 32'h0), acc: cyc + 1, lat: lat});
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send timeout: cmd %0d din %h never accepted", c, d);
        end
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d results still missing, expected 0", nm, sb.size());
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (hold_en && prev_hold) begin
            chk("stall out_valid held", out_valid, 1);
            chk("stall dout stable", dout, prev_dout);
        end
        prev_hold = out_valid && !out_ready;
        prev_dout = dout;
        if (out_valid && out_ready && !flush && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: got %h, expected no result", dout);
            end else begin
                e = sb.pop_front();
                chk("dout", dout, e.data);
                chk("zero", zero, e.zero);
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Random streams against a direct reference model.
    for (genvar wi = 0; wi < 3; wi++) begin : g_w
        localparam int W = (wi == 0) ? 8 : ((wi == 1) ? 32 : 64);
        localparam int L = $clog2(W);
        for (genvar st = 1; st <= L; st++) begin : g_s
            logic [W-1:0] rd;
            logic [W-1:0] ro;
            logic [L-1:0] rs;
            logic [2:0]   rc;
            logic         riv, rir, rov, rorr, rz;
            logic [W-1:0] rq[$];

            shifter_pipe #(.WIDTH(W), .STAGES(st)) u_rdut (
                .CLK(clk), .RESET(rrst), .DIN_SP(rd), .SHIFT_VAL_SP(rs), .CMD_SP(rc),
                .IN_VALID_SP(riv), .IN_READY_SP(rir), .FLUSH_SP(1'b0),
                .DOUT_SP(ro), .ZERO_SP(rz), .OUT_VALID_SP(rov), .OUT_READY_SP(rorr)
            );

            function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x,
                                                       input logic [L-1:0] s,
                                                       input logic [2:0] c);
                logic signed [W-1:0] sx;
                int n;
                sx = x;
                n = int'(s);
                case (c)
                    3'd0: return x << n;
                    3'd1: return x >> n;
                    3'd2: return W'(sx >>> n);
                    3'd3: return (n == 0) ? x : ((x << n) | (x >> (W - n)));
                    3'd4: return (n == 0) ? x : ((x >> n) | (x << (W - n)));
                    default: return x;
                endcase
            endfunction

            initial begin
                int sent;
                int budget;
                sent = 0;
                budget = 0;
                riv = 1'b0; rorr = 1'b0; rd = '0; rs = '0; rc = '0;
                wait (rrst === 1'b0);
                @(posedge clk); #1;
                while (sent < 150 && budget < 3000) begin
                    riv  = ($urandom_range(0, 3) != 0);
                    rd   = W'({$urandom(), $urandom()});
                    rs   = L'($urandom());
                    rc   = 3'($urandom_range(0, 7));
                    rorr = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (riv && rir) begin
                        rq.push_back(ref_shift(rd, rs, rc));
                        sent++;
                    end
                    @(posedge clk); #1;
                    budget++;
                end
                riv = 1'b0;
                rorr = 1'b1;
                for (int k = 0; k < 200 && rq.size() != 0; k++) @(posedge clk);
                #1;
                checks++;
                if (sent < 150 || rq.size() != 0) begin
                    errors++;
                    $display("FAIL rand W%0d S%0d: sent %0d of 150, %0d results missing",
                             W, st, sent, rq.size());
                end
                done_cnt++;
            end

            always @(negedge clk) begin
                logic [W-1:0] e;
                if (!rrst && rov && rorr) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand W%0d S%0d unexpected output: got %h", W, st, ro);
                    end else begin
                        e = rq.pop_front();
                        chk($sformatf("rand W%0d S%0d dout", W, st), 64'(ro), 64'(e));
                        chk($sformatf("rand W%0d S%0d zero", W, st), 64'(rz), 64'(e == '0));
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        int n;
        int seen;
        logic [31:0] d4 [4];
        logic [4:0]  s4 [4];
        logic [2:0]  c4 [4];
        logic [31:0] e4 [4];

        clk = 1'b0; rst = 1'b1; rrst = 1'b1;
        din = '0; shv = '0; cmd = '0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset dout", dout, 0);
        chk("reset zero", zero, 1);
        chk("reset in_ready", in_ready, 1);

        @(posedge clk); #1;
        rst = 1'b0;
        rrst = 1'b0;

        // directed vectors, free-flowing output
        send(32'h8000_0000, 5'd31, 3'b010, 32'hFFFF_FFFF, 1);
        send(32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001, 0);
        send(32'h0000_0001, 5'd1,  3'b100, 32'h8000_0000, 0);
        send(32'h8000_0000, 5'd4,  3'b011, 32'h0000_0008, 0);
        send(32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, 0);
        for (int c = 0; c < 5; c++)
            send(32'hA5C3_0F96, 5'd0, 3'(c), 32'hA5C3_0F96, 0);
        send(32'h1234_5678, 5'd5,  3'b111, 32'h1234_5678, 0);
        send(32'h1234_5678, 5'd9,  3'b101, 32'h1234_5678, 0);
        send(32'h0000_00F0, 5'd4,  3'b010, 32'h0000_000F, 0);
        send(32'hF000_000F, 5'd8,  3'b100, 32'h0FF0_0000, 0);
        send(32'h0000_0003, 5'd17, 3'b000, 32'h0006_0000, 0);
        send(32'h0000_0001, 5'd0,  3'b000, 32'h0000_0001, 0);
        send(32'h0000_0001, 5'd1,  3'b001, 32'h0000_0000, 0);
        drain("directed");

        // backpressure: output stalled, four back-to-back requests
        d4 = '{32'h3, 32'hF0, 32'h1, 32'h8000_0000};
        s4 = '{5'd1, 5'd4, 5'd8, 5'd3};
        c4 = '{3'b000, 3'b001, 3'b011, 3'b010};
        e4 = '{32'h6, 32'hF, 32'h100, 32'hF000_0000};
        out_ready = 1'b0;
        hold_en = 1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            din = d4[i]; shv = s4[i]; cmd = c4[i]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{data: e4[i], zero: 1'b0, acc: 0, lat: 0});
                acc++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall accepted count", acc, 3);
        chk("stall in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("stall drain cycles", n, 3);
        hold_en = 0;

        // flush with two requests in flight and a new request offered
        @(posedge clk); #1;
        send(32'h0000_0011, 5'd1, 3'b000, 32'h0000_0022, 0);
        send(32'h0000_0044, 5'd2, 3'b001, 32'h0000_0011, 0);
        flush = 1'b1;
        din = 32'hDEAD_BEEF; shv = 5'd0; cmd = 3'b111; in_valid = 1'b1;
        @(negedge clk);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush out_valid", out_valid, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush nothing emerges", seen, 0);

        // asynchronous reset pulse with a full pipeline
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h0000_0001, 5'd3, 3'b000, 32'h0000_0008, 0);
        send(32'h0000_0002, 5'd3, 3'b000, 32'h0000_0010, 0);
        send(32'h0000_0004, 5'd3, 3'b000, 32'h0000_0020, 0);
        @(negedge clk);
        chk("pre-reset out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset dout", dout, 0);
        chk("async reset zero", zero, 1);
        chk("async reset in_ready", in_ready, 1);
        sb.delete();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(32'h0000_0005, 5'd2, 3'b000, 32'h0000_0014, 0);
        drain("post-reset");

        for (int k = 0; k < 20000 && done_cnt < NCFG; k++) @(posedge clk);
        #1;
        checks++;
        if (done_cnt < NCFG) begin
            errors++;
            $display("FAIL random streams: %0d of %0d finished", done_cnt, NCFG);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
